// File: rtl/alu_pipe_16_pkg.sv
// rtl/alu_pipe_16_pkg.sv - ctrl bit positions, named ctrl encodings and stage-1 payload type for the Hack ALU pipe
package alu_pipe_16_pkg;

  localparam int ALU_ZX = 5;
  localparam int ALU_NX = 4;
  localparam int ALU_ZY = 3;
  localparam int ALU_NY = 2;
  localparam int ALU_F  = 1;
  localparam int ALU_NO = 0;

  localparam logic [5:0] ALU_ZERO = 6'b101010;
  localparam logic [5:0] ALU_ONE  = 6'b111111;
  localparam logic [5:0] ALU_NEG1 = 6'b111010;
  localparam logic [5:0] ALU_X    = 6'b001100;
  localparam logic [5:0] ALU_XPY  = 6'b000010;
  localparam logic [5:0] ALU_XMY  = 6'b010011;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctrl;
  } alu_op_t;

endpackage

// File: rtl/alu_core_16.sv
// rtl/alu_core_16.sv - combinational 16-bit Hack ALU; ALU_OVF_EN adds signed-add overflow output ovf
module alu_not16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  assign y = ~a;
endmodule

module alu_core_16
  import alu_pipe_16_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [5:0]  ctrl,
  output logic [15:0] out,
  output logic        zr,
`ifdef ALU_OVF_EN
  output logic        ovf,
`endif
  output logic        ng
);

  logic [15:0] xa, xa_n, xb;
  logic [15:0] ya, ya_n, yb;
  logic [15:0] r, r_n;

  assign xa = ctrl[ALU_ZX] ? 16'h0000 : x;
  assign ya = ctrl[ALU_ZY] ? 16'h0000 : y;

  alu_not16 u_not_x (.a(xa), .y(xa_n));
  alu_not16 u_not_y (.a(ya), .y(ya_n));

  assign xb = ctrl[ALU_NX] ? xa_n : xa;
  assign yb = ctrl[ALU_NY] ? ya_n : ya;

  // 16-bit sum drops the carry out of bit 15
  assign r = ctrl[ALU_F] ? (xb + yb) : (xb & yb);

  alu_not16 u_not_r (.a(r), .y(r_n));

  assign out = ctrl[ALU_NO] ? r_n : r;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];

`ifdef ALU_OVF_EN
  assign ovf = ctrl[ALU_F] & (xb[15] == yb[15]) & (r[15] != xb[15]);
`endif

endmodule

// File: rtl/alu_pipe_16.sv
// rtl/alu_pipe_16.sv - two-stage valid/ready pipelined Hack ALU; ALU_OVF_EN adds registered ovf output
module alu_pipe_16
  import alu_pipe_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
`ifdef ALU_OVF_EN
  output logic             ovf,
`endif
  output logic             ng
);

  logic            s2_adv, s1_adv;
  logic            s1_valid_q, s1_valid_d;
  alu_op_t         s1_op_q, s1_op_d;
  logic            s2_valid_q, s2_valid_d;
  logic [15:0]     out_q, out_d, core_out;
  logic            zr_q, zr_d, core_zr;
  logic            ng_q, ng_d, core_ng;
`ifdef ALU_OVF_EN
  logic            ovf_q, ovf_d, core_ovf;
`endif

  alu_core_16 u_core (
    .x    (s1_op_q.x),
    .y    (s1_op_q.y),
    .ctrl (s1_op_q.ctrl),
    .out  (core_out),
    .zr   (core_zr),
`ifdef ALU_OVF_EN
    .ovf  (core_ovf),
`endif
    .ng   (core_ng)
  );

  always_comb begin
    // No skid buffer: in_ready ripples combinationally back from out_ready
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
`ifdef ALU_OVF_EN
    ovf_d      = ovf_q;
`endif

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = '{x: x[15:0], y: y[15:0], ctrl: ctrl};
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = core_out;
        zr_d  = core_zr;
        ng_d  = core_ng;
`ifdef ALU_OVF_EN
        ovf_d = core_ovf;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
`ifdef ALU_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out       = WIDTH'(out_q);
  assign zr        = zr_q;
  assign ng        = ng_q;
`ifdef ALU_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_pipe_16.sv
// tb/tb_alu_pipe_16.sv - directed and randomized self-checking bench for alu_pipe_16 (ALU_OVF_EN aware)
module tb_alu_pipe_16;
  import alu_pipe_16_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, out;
  logic [5:0]  ctrl;
  logic        zr, ng;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  alu_pipe_16 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
`ifdef ALU_OVF_EN
    .ovf       (ovf),
`endif
    .ng        (ng)
  );

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  int got = 0;
  logic acc;
  logic stall_prev = 1'b0;
  logic [15:0] out_prev;
  logic zr_prev, ng_prev;
  logic d_valid, d_ready;
  logic [15:0] d_x, d_y;
  logic [5:0] d_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, out} from the arithmetic definition of the Hack ALU
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
    int xa, ya, xb, yb, r, s;
    logic ov;
    xa = c[5] ? 0 : int'(a);
    ya = c[3] ? 0 : int'(b);
    xb = c[4] ? 65535 - xa : xa;
    yb = c[2] ? 65535 - ya : ya;
    r  = c[1] ? (xb + yb) % 65536 : (xb & yb);
    if (c[0]) r = 65535 - r;
    s  = (xb >= 32768 ? xb - 65536 : xb) + (yb >= 32768 ? yb - 65536 : yb);
    ov = c[1] && (s > 32767 || s < -32768);
    return {ov, r[15:0]};
  endfunction

  task automatic step();
    logic [16:0] e;
    @(negedge clk);
    in_valid = d_valid; x = d_x; y = d_y; ctrl = d_ctrl; out_ready = d_ready;
    #1;
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_out", 32'(out), 32'(out_prev));
      chk("stall_flags", {30'd0, zr, ng}, {30'd0, zr_prev, ng_prev});
    end
    if (out_valid && out_ready) begin
      chk("expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_out", 32'(out), 32'(e[15:0]));
        chk("res_zr", 32'(zr), 32'(e[15:0] == 16'h0));
        chk("res_ng", 32'(ng), 32'(e[15]));
`ifdef ALU_OVF_EN
        chk("res_ovf", 32'(ovf), 32'(e[16]));
`endif
        got++;
      end
    end
    stall_prev = out_valid && !out_ready;
    out_prev = out; zr_prev = zr; ng_prev = ng;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_alu(x, y, ctrl));
  endtask

  logic [15:0] dx[4], dy[4];
  logic [5:0]  dc[4];
  logic [15:0] dout[4];
  int k, g0, sent, cyc;

  initial begin
    reset = 1'b1; in_valid = 0; x = 0; y = 0; ctrl = 0; out_ready = 0;
    d_valid = 0; d_x = 0; d_y = 0; d_ctrl = 0; d_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_flags", {30'd0, zr, ng}, 32'd0);
    reset = 1'b0;

    // Single op latency and one-cycle valid pulse
    d_valid = 1; d_x = 16'd5; d_y = 16'd3; d_ctrl = ALU_XPY; d_ready = 1;
    step();
    d_valid = 0;
    step();
    chk("xpy_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("xpy_valid", 32'(out_valid), 32'd1);
    chk("xpy_out", 32'(out), 32'd8);
    chk("xpy_flags", {30'd0, zr, ng}, 32'd0);
    step();
    chk("xpy_pulse", 32'(out_valid), 32'd0);

    dx = '{16'd5, 16'd5, 16'd5, 16'h1234};
    dy = '{16'd3, 16'd3, 16'd3, 16'h4321};
    dc = '{ALU_XMY, ALU_ZERO, ALU_NEG1, ALU_ONE};
    dout = '{16'd2, 16'h0000, 16'hFFFF, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      d_valid = 1; d_x = dx[i]; d_y = dy[i]; d_ctrl = dc[i];
      step();
      d_valid = 0;
      step();
      step();
      chk("dir_valid", 32'(out_valid), 32'd1);
      chk("dir_out", 32'(out), 32'(dout[i]));
      chk("dir_zr", 32'(zr), 32'(dout[i] == 16'h0));
      chk("dir_ng", 32'(ng), 32'(dout[i][15]));
    end
    step();

`ifdef ALU_OVF_EN
    d_valid = 1; d_x = 16'h7FFF; d_y = 16'h0001; d_ctrl = ALU_XPY;
    step();
    d_valid = 0;
    step();
    step();
    chk("ovf_out", 32'(out), 32'h8000);
    chk("ovf_ng", 32'(ng), 32'd1);
    chk("ovf_set", 32'(ovf), 32'd1);
    d_valid = 1; d_x = 16'd5; d_y = 16'd3;
    step();
    d_valid = 0;
    step();
    step();
    chk("ovf_clear", 32'(ovf), 32'd0);
    step();
`endif

    // Back-pressure: both stages fill then in_ready drops
    dx = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    dy = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    dc = '{ALU_XPY, ALU_XMY, ALU_X, ALU_XPY};
    k = 0; d_ready = 0;
    for (int c = 0; c < 4; c++) begin
      d_valid = 1; d_x = dx[k]; d_y = dy[k]; d_ctrl = dc[k];
      step();
      if (acc) k++;
    end
    chk("stall_accepts", 32'(k), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    g0 = got; d_ready = 1;
    for (int c = 0; c < 4; c++) begin
      d_valid = (k < 4);
      if (k < 4) begin d_x = dx[k]; d_y = dy[k]; d_ctrl = dc[k]; end
      step();
      if (acc) k++;
    end
    chk("release_rate", 32'(got - g0), 32'd4);
    chk("release_accepts", 32'(k), 32'd4);
    d_valid = 0;
    step();
    chk("release_drained", 32'(out_valid), 32'd0);

    // Randomized traffic against the reference model
    g0 = got; sent = 0; cyc = 0;
    while (got - g0 < 1000 && cyc < 20000) begin
      d_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      d_x = 16'($urandom); d_y = 16'($urandom);
      d_ctrl = ($urandom_range(0, 1) == 1) ? 6'($urandom) : dc[$urandom_range(0, 3)];
      d_ready = ($urandom_range(0, 3) != 0);
      step();
      if (acc) sent++;
      cyc++;
    end
    chk("random_done", 32'(got - g0), 32'd1000);
    d_valid = 0; d_ready = 1;
    step();

    // Reset with two ops in flight discards them
    d_ready = 0; d_valid = 1; d_x = 16'h00AA; d_y = 16'h0055; d_ctrl = ALU_XPY;
    step();
    step();
    d_valid = 0;
    step();
    chk("pre_reset_full", 32'(out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_reset_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_ready", 32'(in_ready), 32'd1);
    chk("mid_reset_out", 32'(out), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    g0 = got; d_ready = 1; d_valid = 1; d_x = 16'h0100; d_y = 16'h0023; d_ctrl = ALU_XMY;
    step();
    d_valid = 0;
    for (int c = 0; c < 4; c++) step();
    chk("post_reset_count", 32'(got - g0), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
